// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: one-hot opcodes, FSM states and
// the control flags carried with each output entry.
package exec_pkg;

  localparam logic [15:0] OP_ADD = 16'h0001;
  localparam logic [15:0] OP_SUB = 16'h0002;
  localparam logic [15:0] OP_LI  = 16'h0004;
  localparam logic [15:0] OP_SHL = 16'h0008;
  localparam logic [15:0] OP_SHR = 16'h0010;
  localparam logic [15:0] OP_AND = 16'h0020;
  localparam logic [15:0] OP_OR  = 16'h0040;
  localparam logic [15:0] OP_XOR = 16'h0080;
  localparam logic [15:0] OP_BR  = 16'h0100;
  localparam logic [15:0] OP_BNE = 16'h0200;
  localparam logic [15:0] OP_MOV = 16'h0400;
  localparam logic [15:0] OP_ADI = 16'h0800;
  localparam logic [15:0] OP_MUL = 16'h1000;
  localparam logic [15:0] OP_HLT = 16'h2000;
  localparam logic [15:0] OP_NOP = 16'h4000;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    HALTED
  } state_t;

  typedef struct packed {
    logic wb_en;
    logic branch;
    logic illegal;
  } entry_ctl_t;

endpackage

// File: rtl/exec_mul.sv
// Counted multiplier: operands latched on start, done raised on the last
// latency cycle and held (counter parked at 0) until the result is taken.
module exec_mul #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              take,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [CW-1:0]     cnt;
  logic              busy;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(MUL_LAT - 1);
      a_q  <= a;
      b_q  <= b;
    end else if (busy) begin
      if (cnt > CW'(1)) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt  <= '0;
        busy <= !take;
      end
    end
  end

  assign done    = busy && (cnt <= CW'(1));
  assign product = a_q * b_q;

endmodule

// File: rtl/execute_unit.sv
// Execute stage with valid/ready handshakes, a single-entry output register,
// a multi-cycle multiplier, sticky halt and illegal-opcode flagging.
module execute_unit
  import exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3,
  parameter int SH_W    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_op,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [SH_W-1:0]   in_shamt,
  input  logic [REG_AW-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_pc,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_wb_en,
  output logic              out_branch,
  output logic              out_illegal,
  output logic              halted
);

  state_t            state;
  entry_ctl_t        ctl_q;
  entry_ctl_t        dec_ctl;
  logic [DATA_W-1:0] dec_result;
  logic [DATA_W-1:0] dec_pc;
  logic              dec_emit;
  logic              dec_mul;
  logic              dec_halt;
  logic              out_free;
  logic              accept;
  logic [DATA_W-1:0] mul_pc_q;
  logic [REG_AW-1:0] mul_dest_q;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign out_free    = !out_valid || out_ready;
  assign in_ready    = (state == IDLE) && out_free;
  assign accept      = in_valid && in_ready;
  assign halted      = (state == HALTED);
  assign out_wb_en   = ctl_q.wb_en;
  assign out_branch  = ctl_q.branch;
  assign out_illegal = ctl_q.illegal;

  always_comb begin
    dec_result = '0;
    dec_pc     = in_pc;
    dec_ctl    = '{wb_en: 1'b1, branch: 1'b0, illegal: 1'b0};
    dec_emit   = 1'b1;
    dec_mul    = 1'b0;
    dec_halt   = 1'b0;
    case (in_op)
      OP_ADD: dec_result = in_rs + in_rt;
      OP_SUB: dec_result = in_rs - in_rt;
      OP_LI:  dec_result = DATA_W'(in_imm[15:0]);
      OP_SHL: dec_result = in_rs << in_shamt;
      OP_SHR: dec_result = in_rs >> in_shamt;
      OP_AND: dec_result = in_rs & in_rt;
      OP_OR:  dec_result = in_rs | in_rt;
      OP_XOR: dec_result = in_rs ^ in_rt;
      OP_MOV: dec_result = in_rs;
      OP_ADI: dec_result = in_rs + in_imm;
      OP_BR: begin
        dec_pc         = in_pc + in_imm;
        dec_ctl.wb_en  = 1'b0;
        dec_ctl.branch = 1'b1;
      end
      OP_BNE: begin
        dec_ctl.wb_en = 1'b0;
        if (in_rs != in_rt) begin
          dec_pc         = in_pc + in_imm;
          dec_ctl.branch = 1'b1;
        end else begin
          dec_pc = in_pc + DATA_W'(1);
        end
      end
      OP_MUL: begin
        // Single-cycle latency bypasses the counted multiplier entirely.
        if (MUL_LAT == 1) begin
          dec_result = in_rs * in_rt;
        end else begin
          dec_emit = 1'b0;
          dec_mul  = 1'b1;
        end
      end
      OP_HLT: begin
        dec_emit = 1'b0;
        dec_halt = 1'b1;
      end
      OP_NOP: dec_emit = 1'b0;
      default: begin
        dec_ctl.wb_en   = 1'b0;
        dec_ctl.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_pc     <= '0;
      out_dest   <= '0;
      ctl_q      <= '0;
      mul_pc_q   <= '0;
      mul_dest_q <= '0;
    end else begin
      // A load later in this block overrides the drain.
      if (out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_emit) begin
              out_valid  <= 1'b1;
              out_result <= dec_result;
              out_pc     <= dec_pc;
              out_dest   <= in_dest;
              ctl_q      <= dec_ctl;
            end
            if (dec_mul) begin
              state      <= MUL_BUSY;
              mul_pc_q   <= in_pc;
              mul_dest_q <= in_dest;
            end
            if (dec_halt) state <= HALTED;
          end
        end
        MUL_BUSY: begin
          if (mul_done && out_free) begin
            out_valid  <= 1'b1;
            out_result <= mul_product;
            out_pc     <= mul_pc_q;
            out_dest   <= mul_dest_q;
            ctl_q      <= '{wb_en: 1'b1, branch: 1'b0, illegal: 1'b0};
            state      <= IDLE;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  exec_mul #(
    .DATA_W (DATA_W),
    .MUL_LAT(MUL_LAT)
  ) u_mul (
    .clock  (clock),
    .reset  (reset),
    .start  (accept && dec_mul),
    .take   (out_free),
    .a      (in_rs),
    .b      (in_rt),
    .done   (mul_done),
    .product(mul_product)
  );

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed scenarios plus randomized traffic checked
// against a transaction-level model of the stage.
module tb_execute_unit;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LAT = 3;
  localparam int SW  = 5;

  localparam logic [15:0] ADD = 16'h0001, SUB = 16'h0002, LI  = 16'h0004;
  localparam logic [15:0] SHL = 16'h0008, SHR = 16'h0010, AND = 16'h0020;
  localparam logic [15:0] OR  = 16'h0040, XOR = 16'h0080, BR  = 16'h0100;
  localparam logic [15:0] BNE = 16'h0200, MOV = 16'h0400, ADI = 16'h0800;
  localparam logic [15:0] MUL = 16'h1000, HLT = 16'h2000, NOP = 16'h4000;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_op;
  logic [DW-1:0] in_pc, in_rs, in_rt, in_imm;
  logic [SW-1:0] in_shamt;
  logic [AW-1:0] in_dest;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result, out_pc;
  logic [AW-1:0] out_dest;
  logic          out_wb_en, out_branch, out_illegal, halted;

  execute_unit #(
    .DATA_W (DW),
    .REG_AW (AW),
    .MUL_LAT(LAT),
    .SH_W   (SW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_pc      (in_pc),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm     (in_imm),
    .in_shamt   (in_shamt),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_pc     (out_pc),
    .out_dest   (out_dest),
    .out_wb_en  (out_wb_en),
    .out_branch (out_branch),
    .out_illegal(out_illegal),
    .halted     (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: entry = {result, pc, dest, wb_en, branch, illegal}; result is 0
  // whenever wb_en is 0 (it carries no meaning there).
  logic        m_full   = 1'b0;
  logic [71:0] m_e      = '0;
  logic        m_pend   = 1'b0;
  logic [71:0] m_pend_e = '0;
  int          m_rem    = 0;
  logic        m_halted = 1'b0;

  logic [15:0] op_tab [18] = '{ADD, SUB, LI, SHL, SHR, AND, OR, XOR, BR, BNE,
                               MOV, ADI, MUL, HLT, NOP, 16'h0000, 16'h8000, 16'h0003};

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind: 0 emit, 1 nop, 2 halt, 3 multiply
  function automatic void ref_exec(input logic [15:0] op, input logic [31:0] pc,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [31:0] imm, input logic [4:0] sh,
                                   input logic [4:0] dest, output int kind,
                                   output logic [71:0] e);
    logic [31:0] r;
    logic [31:0] p;
    logic        wb, br, il;
    r = 0; p = pc; wb = 1; br = 0; il = 0; kind = 0;
    case (op)
      ADD: r = rs + rt;
      SUB: r = rs - rt;
      LI:  r = {16'h0000, imm[15:0]};
      SHL: r = rs << sh;
      SHR: r = rs >> sh;
      AND: r = rs & rt;
      OR:  r = rs | rt;
      XOR: r = rs ^ rt;
      MOV: r = rs;
      ADI: r = rs + imm;
      BR:  begin p = pc + imm; br = 1; wb = 0; end
      BNE: begin
        wb = 0;
        if (rs != rt) begin p = pc + imm; br = 1; end
        else p = pc + 1;
      end
      MUL: begin r = rs * rt; kind = 3; end
      HLT: kind = 2;
      NOP: kind = 1;
      default: begin wb = 0; il = 1; end
    endcase
    e = {wb ? r : 32'h0, p, dest, wb, br, il};
  endfunction

  function automatic logic exp_ready();
    return !m_halted && !m_pend && (!m_full || out_ready);
  endfunction

  task automatic step(input logic v, input logic [15:0] op, input logic [31:0] pc,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                      input logic [4:0] sh, input logic [4:0] dest, input logic rdy);
    logic        acc, free;
    logic [71:0] got, e;
    int          kind;
    @(negedge clock);
    in_valid = v; in_op = op; in_pc = pc; in_rs = rs; in_rt = rt;
    in_imm = imm; in_shamt = sh; in_dest = dest; out_ready = rdy;
    #1;
    check("in_ready", in_ready, exp_ready());
    check("out_valid", out_valid, m_full);
    check("halted", halted, m_halted);
    if (m_full) begin
      got = {(m_e[2] ? out_result : 32'h0), out_pc, out_dest, out_wb_en, out_branch, out_illegal};
      check("entry", got, m_e);
    end
    acc  = v && exp_ready();
    free = !m_full || rdy;
    if (m_full && rdy) m_full = 1'b0;
    if (m_pend) begin
      if (m_rem > 1) m_rem--;
      else if (free) begin m_full = 1'b1; m_e = m_pend_e; m_pend = 1'b0; end
    end else if (acc) begin
      ref_exec(op, pc, rs, rt, imm, sh, dest, kind, e);
      if (kind == 2) m_halted = 1'b1;
      else if (kind == 3 && LAT > 1) begin m_pend = 1'b1; m_pend_e = e; m_rem = LAT - 1; end
      else if (kind != 1) begin m_full = 1'b1; m_e = e; end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, NOP, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic at_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_halted", halted, 0);
    m_full = 1'b0; m_pend = 1'b0; m_rem = 0; m_halted = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);
  endtask

  initial begin
    int halt_cnt;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_pc = '0; in_rs = '0; in_rt = '0;
    in_imm = '0; in_shamt = '0; in_dest = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_flags", {out_wb_en, out_branch, out_illegal}, 0);
    check("rst_result", out_result, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    step(1, ADD, 32'h40, 5, 7, 0, 0, 3, 1);
    at_edge();
    check("add_result", out_result, 12);
    check("add_dest", out_dest, 3);
    check("add_wb", out_wb_en, 1);
    step(1, SUB, 32'h44, 5, 7, 0, 0, 4, 1);
    at_edge();
    check("sub_result", out_result, 32'hFFFF_FFFE);

    step(1, BNE, 32'h10, 1, 2, 32'hFFFF_FFFC, 0, 0, 1);
    at_edge();
    check("bne_taken_pc", out_pc, 32'h0C);
    check("bne_taken_br", out_branch, 1);
    step(1, BNE, 32'h10, 9, 9, 32'hFFFF_FFFC, 0, 0, 1);
    at_edge();
    check("bne_fall_pc", out_pc, 32'h11);
    check("bne_fall_flags", {out_branch, out_wb_en}, 0);

    step(1, MUL, 32'h20, 32'h10000, 32'h10000, 0, 0, 7, 1);
    at_edge();
    check("mul_busy1_ready", in_ready, 0);
    check("mul_busy1_valid", out_valid, 0);
    idle(1);
    at_edge();
    check("mul_busy2_ready", in_ready, 0);
    check("mul_busy2_valid", out_valid, 0);
    idle(1);
    at_edge();
    check("mul_done_valid", out_valid, 1);
    check("mul_result", out_result, 0);
    check("mul_dest", out_dest, 7);

    step(1, ADD, 0, 1, 2, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, ADD, 0, 50, 50, 0, 0, 2, 0);
      at_edge();
      check("bp_hold_result", out_result, 3);
      check("bp_hold_ready", in_ready, 0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1, ADD, 0, i, 100, 0, 0, 5, 1);
      at_edge();
      check("stream_result", out_result, 100 + i);
    end

    step(1, 16'h0003, 32'h88, 1, 1, 0, 0, 9, 1);
    at_edge();
    check("illegal_flag", out_illegal, 1);
    check("illegal_wb", out_wb_en, 0);

    step(1, HLT, 0, 0, 0, 0, 0, 0, 1);
    at_edge();
    check("hlt_halted", halted, 1);
    check("hlt_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) step(1, ADD, 0, 1, 1, 0, 0, 1, 1);
    do_reset();

    step(1, ADD, 0, 4, 4, 0, 0, 2, 0);
    at_edge();
    check("hold_before_rst", out_valid, 1);
    do_reset();
    step(1, MUL, 0, 3, 3, 0, 0, 6, 1);
    at_edge();
    check("mul_mid_ready", in_ready, 0);
    do_reset();
    for (int i = 0; i < 4; i++) idle(1);

    halt_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] op;
      logic [31:0] rs, rt;
      op = op_tab[$urandom_range(0, 17)];
      if (op == HLT && $urandom_range(0, 3) != 0) op = NOP;
      if ($urandom_range(0, 19) == 0) op = 16'($urandom);
      rs = $urandom;
      rt = (op == BNE && $urandom_range(0, 1) == 0) ? rs : $urandom;
      step($urandom_range(0, 3) != 0, op, $urandom, rs, rt, $urandom,
           5'($urandom), 5'($urandom), $urandom_range(0, 3) != 0);
      if (m_halted) halt_cnt++;
      if (halt_cnt > 3 || $urandom_range(0, 199) == 0) begin
        do_reset();
        halt_cnt = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Parametrised execute stage sitting between decode and write-back; successor to the fixed 32-bit, always-accepting execute stage.
- Adds a valid/ready handshake on both sides and a single-entry output register with backpressure.
- Adds a multi-cycle multiplier with a configurable latency, a sticky halt state and illegal-opcode flagging.
- Keeps the one-hot 16-bit opcode encoding used by decode.

Parameters:
- DATA_W, 32, operand/result/PC width
- REG_AW, 5, destination register address width
- MUL_LAT, 3, multiply latency in cycles from accept to out_valid (≥1)
- SH_W, 5, shift-amount width (= clog2(DATA_W))

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  unit accepts this cycle
- in_op  in  16  one-hot opcode
- in_pc  in  DATA_W  instruction PC
- in_rs  in  DATA_W  source operand
- in_rt  in  DATA_W  target operand
- in_imm  in  DATA_W  sign-extended immediate
- in_shamt  in  SH_W  shift amount
- in_dest  in  REG_AW  destination register
- out_valid  out  1  result entry valid
- out_ready  in  1  write-back consumes the entry
- out_result  out  DATA_W  ALU result
- out_pc  out  DATA_W  PC or branch target
- out_dest  out  REG_AW  destination register
- out_wb_en  out  1  write result to out_dest
- out_branch  out  1  redirect fetch to out_pc
- out_illegal  out  1  opcode not recognised
- halted  out  1  HLT executed, unit frozen

Behaviour:
- Reset (async):
  - state=IDLE, mul counter=0.
  - All outputs 0 except in_ready, which is combinational and becomes 1 once reset deasserts.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Output entry holds stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new entry loads in the same cycle.
- Single-cycle ops: accepted at edge N, entry valid after edge N (latency 1). Throughput is 1 per cycle with out_ready=1.
  - ADD 0x0001: rs+rt
  - SUB 0x0002: rs-rt
  - LI 0x0004: {0, imm[15:0]}
  - SHL 0x0008: rs<<shamt
  - SHR 0x0010: rs>>shamt (logical)
  - AND 0x0020, OR 0x0040, XOR 0x0080: rs op rt
  - MOV 0x0400: rs
  - ADI 0x0800: rs+imm
  - For all of these: wb_en=1, branch=0, out_pc=in_pc.
  - Arithmetic wraps modulo 2^DATA_W; no carry or overflow output.
- Branch ops:
  - BR 0x0100: out_pc=pc+imm, branch=1, wb_en=0.
  - BNE 0x0200, taken (rs≠rt): same as BR.
  - BNE, not taken: out_pc=pc+1, branch=0, wb_en=0; the entry is still emitted.
- MUL 0x1000:
  - States IDLE→MUL_BUSY on accept; operands are latched.
  - Counter runs MUL_LAT-1 cycles; the entry is loaded on the last one (out_valid MUL_LAT cycles after accept). Result is the low DATA_W bits of rs*rt, wb_en=1.
  - in_ready=0 while in MUL_BUSY.
  - If the output register is still full when the counter expires, stay in MUL_BUSY with the counter at 0 until it drains.
  - MUL_LAT=1 behaves as a single-cycle op.
- HLT 0x2000:
  - Accepted, no entry emitted; state→HALTED, halted=1, in_ready=0.
  - Leaves HALTED only through reset.
  - A pending output entry still drains.
- NOP 0x4000: accepted, no entry emitted.
- Any other in_op (zero, multi-hot, 0x8000): emit an entry with out_illegal=1, wb_en=0, branch=0, out_pc=in_pc.
- Reset mid-MUL or while holding an entry: discarded immediately, no output.

Decomposition:
- Package exec_pkg: opcode one-hot localparams, state enum {IDLE, MUL_BUSY, HALTED}, an output-entry struct.
- Sub-module exec_mul: pipelined/counted multiplier with start/done, parametrised DATA_W, MUL_LAT.

Test Plan:
- ADD rs=5, rt=7, dest=3, out_ready=1 -> one cycle later out_result=12, out_dest=3, wb_en=1; SUB 5-7 -> 0xFFFFFFFE.
- BNE pc=0x10, rs=1, rt=2, imm=-4 -> out_pc=0x0C, branch=1. Same with rs=rt=9 -> out_pc=0x11, branch=0, wb_en=0.
- MUL 0x10000×0x10000 with MUL_LAT=3 -> in_ready=0 for 2 cycles, out_valid 3 cycles after accept, out_result=0.
- Hold out_ready=0 for 4 cycles after an ADD -> entry stable, in_ready=0; releasing out_ready gives a back-to-back stream at 1/cycle.
- HLT followed by an ADD on in_valid -> halted=1, ADD never accepted; async reset pulse -> halted=0, in_ready=1.
- in_op=0x0003 -> out_illegal=1, wb_en=0. Reset asserted mid-MUL -> out_valid=0 immediately, state IDLE.
